decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_if.sv | 32 +++
 rtl/decode_stage.sv | 74 +++++++
 tb/tb_decode_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The master side drives fetch inputs and execute ready; the slave side is the decode stage.
interface decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs;
  logic [3:0]  out_rt;
  logic [17:0] out_imm18;
  logic [21:0] out_md22;
  logic [1:0]  out_fmt;
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm18, out_md22, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
           out_imm18, out_md22, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Decode pipeline stage: two-entry skid buffer between fetch and execute,
// with field slicing of the presented word and a saturating output-stall counter.
module decode_stage #(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  decode_if.slave            bus,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;

  logic accept;
  logic release_w;

  // in_ready depends only on registered state so fetch never sees a path from out_ready.
  assign bus.in_ready = ~skid_q.valid;
  assign accept       = bus.in_valid & ~skid_q.valid;
  assign release_w    = main_q.valid & bus.out_ready;

  // NOTE: both entries are reset in full (not just valid) so all out_* fields read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else begin
      if (!main_q.valid || release_w) begin
        if (skid_q.valid) begin
          main_q       <= skid_q;
          skid_q.valid <= 1'b0;
        end else if (accept) begin
          main_q <= '{valid: 1'b1, pc: bus.in_pc, inst: bus.in_inst};
        end else begin
          main_q.valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= '{valid: 1'b1, pc: bus.in_pc, inst: bus.in_inst};
      end
    end
  end

  // Stall cycles keep counting through a flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_q.valid && !bus.out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign bus.out_valid   = main_q.valid;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_opcode  = main_q.inst[31:26];
  assign bus.out_rd      = main_q.inst[25:22];
  assign bus.out_rs      = main_q.inst[21:18];
  assign bus.out_rt      = main_q.inst[17:14];
  assign bus.out_imm18   = main_q.inst[17:0];
  assign bus.out_md22    = main_q.inst[21:0];
  assign bus.out_fmt     = main_q.inst[31:30];
  assign bus.out_illegal = main_q.valid & (main_q.inst[31:30] == 2'b11);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode fields, streaming, backpressure,
// flush, illegal formats, stall-counter saturation and asynchronous reset.
module tb_decode_stage;
  localparam int SW = 8;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] stall_cnt;
  int            n_checks;
  int            n_fail;

  decode_if dif ();

  decode_stage #(.STALL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (dif),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.in_valid  = 1'b0;
    dif.in_inst   = 32'h0;
    dif.in_pc     = 32'h0;
    dif.flush     = 1'b0;
    dif.out_ready = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    dif.in_valid = 1'b1;
    dif.in_inst  = inst;
    dif.in_pc    = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", dif.out_valid); end
    n_checks++; if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", dif.in_ready); end
    n_checks++; if ({dif.out_pc, dif.out_opcode, dif.out_imm18, dif.out_md22, dif.out_fmt, dif.out_illegal} !== '0)
      begin n_fail++; $display("FAIL reset_fields: pc=%h op=%h imm=%h md=%h fmt=%0d ill=%b want all 0", dif.out_pc, dif.out_opcode, dif.out_imm18, dif.out_md22, dif.out_fmt, dif.out_illegal); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_checks++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset: valid=%b ready=%b want 0/1", dif.out_valid, dif.in_ready); end
  endtask

  task automatic test_single();
    reset_dut();
    dif.out_ready = 1'b1;
    drive(32'h1648_0005, 32'h100);
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", dif.out_valid); end
    n_checks++; if (dif.out_pc !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h want 00000100", dif.out_pc); end
    n_checks++; if (dif.out_opcode !== 6'h05 || dif.out_rd !== 4'd9 || dif.out_rs !== 4'd2 || dif.out_rt !== 4'd0)
      begin n_fail++; $display("FAIL single_regs: op=%h rd=%0d rs=%0d rt=%0d want 05/9/2/0", dif.out_opcode, dif.out_rd, dif.out_rs, dif.out_rt); end
    n_checks++; if (dif.out_imm18 !== 18'h00005 || dif.out_md22 !== 22'h080005)
      begin n_fail++; $display("FAIL single_imm: imm18=%h md22=%h want 00005/080005", dif.out_imm18, dif.out_md22); end
    // Opcode 0x05 has top bits 00, so the format slice is R.
    n_checks++; if (dif.out_fmt !== 2'd0 || dif.out_illegal !== 1'b0)
      begin n_fail++; $display("FAIL single_fmt: fmt=%0d ill=%b want 0/0", dif.out_fmt, dif.out_illegal); end
    step();
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", dif.out_valid); end
  endtask

  task automatic test_back_to_back();
    int errs;
    reset_dut();
    dif.out_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(32'h0400_0000 + 32'(i), 32'h200 + 32'(4 * i));
      step();
      if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h200 + 32'(4 * i) || dif.in_ready !== 1'b1) begin
        errs++;
        $display("FAIL b2b_word%0d: valid=%b pc=%h ready=%b want 1/%h/1", i, dif.out_valid, dif.out_pc, dif.in_ready, 32'h200 + 32'(4 * i));
      end
    end
    n_checks++; if (errs != 0) n_fail++;
    dif.in_valid = 1'b0;
    step();
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", dif.out_valid); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    drive(32'h0400_00A0, 32'h300);
    step();
    n_checks++; if (dif.out_pc !== 32'h300 || dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first: pc=%h ready=%b want 300/1", dif.out_pc, dif.in_ready); end
    drive(32'h0400_00B0, 32'h304);
    step();
    n_checks++; if (dif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready=%b want 0", dif.in_ready); end
    drive(32'h0400_00C0, 32'h308);
    step();
    step();
    n_checks++; if (dif.out_pc !== 32'h300 || dif.out_opcode !== 6'h01 || dif.out_imm18 !== 18'h000A0)
      begin n_fail++; $display("FAIL bp_hold: pc=%h op=%h imm=%h want 300/01/000a0", dif.out_pc, dif.out_opcode, dif.out_imm18); end
    n_checks++; if (stall_cnt !== SW'(3)) begin n_fail++; $display("FAIL bp_stall: got %0d want 3", stall_cnt); end
    dif.out_ready = 1'b1;
    step();
    n_checks++; if (dif.out_pc !== 32'h304 || dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain1: pc=%h ready=%b want 304/1", dif.out_pc, dif.in_ready); end
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_pc !== 32'h308 || dif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain2: pc=%h valid=%b want 308/1", dif.out_pc, dif.out_valid); end
    step();
    n_checks++; if (dif.out_valid !== 1'b0 || stall_cnt !== SW'(3)) begin n_fail++; $display("FAIL bp_empty: valid=%b stall=%0d want 0/3", dif.out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    int leaks;
    reset_dut();
    drive(32'h0400_0001, 32'h400);
    step();
    drive(32'h0400_0002, 32'h404);
    step();
    drive(32'h0400_0003, 32'h4F0);
    dif.flush = 1'b1;
    step();
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state: valid=%b ready=%b want 0/1", dif.out_valid, dif.in_ready); end
    n_checks++; if (stall_cnt !== SW'(2)) begin n_fail++; $display("FAIL flush_stall: got %0d want 2", stall_cnt); end
    dif.out_ready = 1'b1;
    leaks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dif.out_valid !== 1'b0) begin leaks++; $display("FAIL flush_leak: pc %h appeared after flush", dif.out_pc); end
    end
    n_checks++; if (leaks != 0) n_fail++;
  endtask

  task automatic test_illegal();
    reset_dut();
    drive(32'hC000_0000, 32'h500);
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_fmt !== 2'd3 || dif.out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_30: fmt=%0d ill=%b want 3/1", dif.out_fmt, dif.out_illegal); end
    step();
    n_checks++; if (dif.out_illegal !== 1'b1 || dif.out_pc !== 32'h500) begin n_fail++; $display("FAIL ill_hold: ill=%b pc=%h want 1/500", dif.out_illegal, dif.out_pc); end
    dif.out_ready = 1'b1;
    drive(32'h8FFF_FFFF, 32'h504);
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_fmt !== 2'd2 || dif.out_illegal !== 1'b0 || dif.out_opcode !== 6'h23)
      begin n_fail++; $display("FAIL ill_20: op=%h fmt=%0d ill=%b want 23/2/0", dif.out_opcode, dif.out_fmt, dif.out_illegal); end
    n_checks++; if (dif.out_rd !== 4'hF || dif.out_rs !== 4'hF || dif.out_rt !== 4'hF || dif.out_imm18 !== 18'h3FFFF || dif.out_md22 !== 22'h3FFFFF)
      begin n_fail++; $display("FAIL ones_fields: rd=%h rs=%h rt=%h imm=%h md=%h want f/f/f/3ffff/3fffff", dif.out_rd, dif.out_rs, dif.out_rt, dif.out_imm18, dif.out_md22); end
    step();
    n_checks++; if (dif.out_illegal !== 1'b0 || dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL ill_empty: ill=%b valid=%b want 0/0", dif.out_illegal, dif.out_valid); end
  endtask

  task automatic test_saturate_and_async_reset();
    reset_dut();
    drive(32'h0400_0077, 32'h600);
    step();
    drive(32'h0400_0078, 32'h604);
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (stall_cnt !== SW'(1)) begin n_fail++; $display("FAIL sat_start: got %0d want 1", stall_cnt); end
    repeat ((1 << SW) + 5) step();
    n_checks++; if (stall_cnt !== {SW{1'b1}}) begin n_fail++; $display("FAIL sat_value: got %0d want %0d", stall_cnt, {SW{1'b1}}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall_cnt !== '0 || dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL async_reset: stall=%0d valid=%b ready=%b want 0/0/1", stall_cnt, dif.out_valid, dif.in_ready); end
    step();
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    drive(32'h0400_0099, 32'h700);
    step();
    dif.in_valid = 1'b0;
    n_checks++; if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h700) begin n_fail++; $display("FAIL reset_refill: valid=%b pc=%h want 1/700", dif.out_valid, dif.out_pc); end
    step();
    n_checks++; if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_stale: pc %h reappeared", dif.out_pc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_saturate_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
